// File: rtl/bridge_utils_pkg.sv
// Shared types for the AXI write-slave reader and its engine.
// Holds the ID width, engine command/status enums and the latched AW payload.
package bridge_utils;

  localparam int unsigned ID_WIDTH        = 4;
  localparam int unsigned INFO_ADDR_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_GET_ADDR,
    RD_GET_DATA,
    RD_SEND_RESP
  } rd_cmd_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_BUSY,
    RD_SWITCH,
    RD_DONE
  } rd_info_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]        id;
    logic [INFO_ADDR_WIDTH-1:0] addr;
    logic [3:0]                 len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
  } addr_info_t;

endpackage

// File: rtl/slave_axi_reader.sv
// AXI write slave that hands AW fields and W beats to an engine under its command.
// Optional: SLAVE_AXI_READER_WLAST_CHECK_EN flags wlast/length disagreement as SLVERR.
module slave_axi_reader
  import bridge_utils::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  rd_cmd_t                 rd_cmd,
  output rd_info_t                rd_info,
  output addr_info_t              addr_info,
  output logic [DATA_WIDTH-1:0]   eng_wdata,
  output logic [DATA_WIDTH/8-1:0] eng_wstrb,
  output logic                    eng_wvalid,
  input  logic                    eng_wready,
  input  logic [1:0]              eng_bresp
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    WAIT_W,
    W,
    WAIT_B,
    B
  } state_t;

  state_t                  state_q, state_d;
  addr_info_t              addr_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic                    ewv_d;
  logic [DATA_WIDTH-1:0]   ewd_d;
  logic [STRB_WIDTH-1:0]   ews_d;
  logic [1:0]              bresp_d;
  logic                    awready_d;
  logic                    bvalid_d;
  rd_info_t                info_d;
  logic                    is_last_beat;
`ifdef SLAVE_AXI_READER_WLAST_CHECK_EN
  logic                    err_q, err_d;
`endif

  // wid is never checked; wlast matters only with the check build.
  logic unused_inputs;
  assign unused_inputs = ^{wid, wlast};

  assign bid          = addr_info.id;
  assign is_last_beat = (cnt_q == addr_info.len);

  // Next-state, holding register and response capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_info;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ewv_d   = eng_wvalid;
    ewd_d   = eng_wdata;
    ews_d   = eng_wstrb;
    bresp_d = bresp;
    wready  = 1'b0;
`ifdef SLAVE_AXI_READER_WLAST_CHECK_EN
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (rd_cmd == RD_GET_ADDR) state_d = AW;
      end
      AW: begin
        if (awvalid) begin
          addr_d.id    = awid;
          addr_d.addr  = INFO_ADDR_WIDTH'(awaddr);
          addr_d.len   = awlen;
          addr_d.size  = awsize;
          addr_d.burst = awburst;
          state_d      = WAIT_W;
        end
      end
      WAIT_W: begin
        if (rd_cmd == RD_GET_DATA) begin
          cnt_d   = 4'd0;
          last_d  = 1'b0;
          state_d = W;
        end
      end
      W: begin
        wready = !last_q && (!eng_wvalid || eng_wready);
        if (eng_wready) ewv_d = 1'b0;
        if (wvalid && wready) begin
          ewv_d = 1'b1;
          ewd_d = wdata;
          ews_d = wstrb;
          // Counter saturates on the last beat so awlen=15 cannot wrap.
          if (is_last_beat) last_d = 1'b1;
          else              cnt_d  = cnt_q + 4'd1;
`ifdef SLAVE_AXI_READER_WLAST_CHECK_EN
          if (wlast != is_last_beat) err_d = 1'b1;
`endif
        end
        if (last_q && (!eng_wvalid || eng_wready)) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (rd_cmd == RD_SEND_RESP) begin
`ifdef SLAVE_AXI_READER_WLAST_CHECK_EN
          bresp_d = err_q ? RESP_SLVERR : eng_bresp;
`else
          bresp_d = eng_bresp;
`endif
          state_d = B;
        end
      end
      B: begin
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SLAVE_AXI_READER_WLAST_CHECK_EN
    if (state_d == IDLE) err_d = 1'b0;
`endif

    awready_d = (state_d == AW);
    bvalid_d  = (state_d == B);
    case (state_d)
      AW, W:          info_d = RD_BUSY;
      WAIT_W, WAIT_B: info_d = RD_SWITCH;
      B:              info_d = RD_DONE;
      default:        info_d = RD_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_info  <= '0;
      cnt_q      <= 4'd0;
      last_q     <= 1'b0;
      eng_wvalid <= 1'b0;
      eng_wdata  <= '0;
      eng_wstrb  <= '0;
      bresp      <= 2'b00;
      awready    <= 1'b0;
      bvalid     <= 1'b0;
      rd_info    <= RD_IDLE;
`ifdef SLAVE_AXI_READER_WLAST_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_info  <= addr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      eng_wvalid <= ewv_d;
      eng_wdata  <= ewd_d;
      eng_wstrb  <= ews_d;
      bresp      <= bresp_d;
      awready    <= awready_d;
      bvalid     <= bvalid_d;
      rd_info    <= info_d;
`ifdef SLAVE_AXI_READER_WLAST_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_slave_axi_reader.sv
// Randomized self-checking bench for slave_axi_reader against a transaction-level model.
module tb_slave_axi_reader;
  import bridge_utils::*;

  localparam int unsigned AW_W = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;
`ifdef SLAVE_AXI_READER_WLAST_CHECK_EN
  localparam bit WCHK = 1'b1;
`else
  localparam bit WCHK = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [ID_WIDTH-1:0] awid = '0;
  logic [AW_W-1:0]     awaddr = '0;
  logic [3:0]          awlen = '0;
  logic [2:0]          awsize = '0;
  logic [1:0]          awburst = '0;
  logic                awvalid = 1'b0;
  logic                awready;
  logic [ID_WIDTH-1:0] wid = '0;
  logic [DW-1:0]       wdata = '0;
  logic [SW-1:0]       wstrb = '0;
  logic                wlast = 1'b0;
  logic                wvalid = 1'b0;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready = 1'b0;
  rd_cmd_t             rd_cmd = RD_NONE;
  rd_info_t            rd_info;
  addr_info_t          addr_info;
  logic [DW-1:0]       eng_wdata;
  logic [SW-1:0]       eng_wstrb;
  logic                eng_wvalid;
  logic                eng_wready = 1'b0;
  logic [1:0]          eng_bresp = 2'b00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  slave_axi_reader #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_cmd(rd_cmd), .rd_info(rd_info), .addr_info(addr_info),
    .eng_wdata(eng_wdata), .eng_wstrb(eng_wstrb),
    .eng_wvalid(eng_wvalid), .eng_wready(eng_wready),
    .eng_bresp(eng_bresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_awready"},    64'(awready), 64'd0);
    check({tag, "_wready"},     64'(wready), 64'd0);
    check({tag, "_bvalid"},     64'(bvalid), 64'd0);
    check({tag, "_eng_wvalid"}, 64'(eng_wvalid), 64'd0);
    check({tag, "_bid_bresp"},  64'({bid, bresp}), 64'd0);
    check({tag, "_addr_info"},  64'(addr_info), 64'd0);
    check({tag, "_eng_beat"},   64'({eng_wstrb, eng_wdata}), 64'd0);
    check({tag, "_rd_info"},    64'(rd_info), 64'(RD_IDLE));
  endtask

  // One full transaction; bad_beat>=0 puts wlast on that beat only, abort_at>=0 resets mid-burst.
  task automatic run_txn(input int len, input int stall_pct, input int gap_pct,
                         input int bwait, input int bad_beat, input int abort_at,
                         input logic [1:0] ebresp, input bit fixed,
                         input logic [AW_W-1:0] a0, input logic [DW-1:0] d0);
    logic [DW-1:0]       dq[$];
    logic [SW-1:0]       sq[$];
    logic [DW+SW-1:0]    got_q[$];
    addr_info_t          exp_ai;
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          exp_resp;
    int sent, cyc, extra, bad_rule;
    bit done;

    id = ID_WIDTH'($urandom);
    exp_ai.id    = id;
    exp_ai.addr  = fixed ? a0 : AW_W'($urandom);
    exp_ai.len   = 4'(len);
    exp_ai.size  = 3'd2;
    exp_ai.burst = 2'b01;
    for (int i = 0; i <= len; i++) begin
      dq.push_back((fixed && i == 0) ? d0 : DW'($urandom));
      sq.push_back(fixed ? {SW{1'b1}} : SW'($urandom));
    end
    exp_resp = (WCHK && bad_beat >= 0 && bad_beat != len) ? RESP_SLVERR : ebresp;

    @(negedge clk);
    check("idle_info", 64'(rd_info), 64'(RD_IDLE));
    rd_cmd = RD_GET_ADDR;
    @(negedge clk);
    rd_cmd = RD_NONE;
    check("aw_phase", 64'({awready, rd_info}), 64'({1'b1, RD_BUSY}));
    repeat ($urandom_range(2)) @(negedge clk);
    awid = id; awaddr = exp_ai.addr; awlen = exp_ai.len;
    awsize = exp_ai.size; awburst = exp_ai.burst; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("aw_done", 64'({awready, rd_info}), 64'({1'b0, RD_SWITCH}));
    check("addr_info", 64'(addr_info), 64'(exp_ai));

    rd_cmd = RD_GET_DATA;
    @(negedge clk);
    rd_cmd = RD_NONE;

    sent = 0; cyc = 0; extra = 0; bad_rule = 0; done = 1'b0;
    while (cyc < 400 && !done) begin
      wvalid     = (sent <= len) && ($urandom_range(99) >= 32'(gap_pct));
      wdata      = (sent <= len) ? dq[sent] : DW'($urandom);
      wstrb      = (sent <= len) ? sq[sent] : SW'($urandom);
      wid        = ID_WIDTH'($urandom);
      wlast      = (bad_beat >= 0) ? (sent == bad_beat) : (sent == len);
      eng_wready = ($urandom_range(99) >= 32'(stall_pct));
      #1;
      if (abort_at >= 0 && sent == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset("abort");
        wvalid = 1'b0; eng_wready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (eng_wvalid && eng_wready) got_q.push_back({eng_wstrb, eng_wdata});
      if (sent > len && wready) extra++;
      if (sent <= len && wready != (!eng_wvalid || eng_wready)) bad_rule++;
      if (wvalid && wready) sent++;
      @(negedge clk);
      cyc++;
      if (rd_info == RD_SWITCH) done = 1'b1;
    end
    wvalid = 1'b0; eng_wready = 1'b0;
    check("w_timeout", 64'(done), 64'd1);
    check("beat_count", 64'(got_q.size()), 64'(len + 1));
    for (int i = 0; i < got_q.size() && i <= len; i++)
      check($sformatf("beat%0d", i), 64'(got_q[i]), 64'({sq[i], dq[i]}));
    check("wready_after_last", 64'(extra), 64'd0);
    check("wready_rule", 64'(bad_rule), 64'd0);
    if (stall_pct == 0 && gap_pct == 0) check("throughput_cycles", 64'(cyc), 64'(len + 2));

    eng_bresp = ebresp;
    rd_cmd = RD_SEND_RESP;
    @(negedge clk);
    rd_cmd = RD_NONE;
    eng_bresp = ~ebresp;
    for (int i = 0; i < bwait; i++) begin
      check("b_hold", 64'({bvalid, bid, bresp, rd_info}), 64'({1'b1, id, exp_resp, RD_DONE}));
      @(negedge clk);
    end
    check("b_resp", 64'({bvalid, bid, bresp, rd_info}), 64'({1'b1, id, exp_resp, RD_DONE}));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done", 64'({bvalid, rd_info}), 64'({1'b0, RD_IDLE}));
  endtask

  initial begin
    #1;
    check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_txn(0, 0, 0, 0, -1, -1, 2'b00, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    run_txn(15, 0, 0, 0, -1, -1, 2'b00, 1'b0, '0, '0);
    run_txn(3, 60, 0, 1, -1, -1, 2'b00, 1'b0, '0, '0);
    run_txn(2, 20, 20, 5, -1, -1, 2'b01, 1'b0, '0, '0);
    run_txn(3, 0, 0, 0, 2, -1, 2'b01, 1'b0, '0, '0);
    run_txn(1, 0, 0, 0, -1, -1, 2'b00, 1'b0, '0, '0);
    run_txn(3, 0, 0, 0, -1, 2, 2'b00, 1'b0, '0, '0);
    run_txn(3, 0, 0, 0, -1, -1, 2'b11, 1'b0, '0, '0);
    for (int t = 0; t < 12; t++)
      run_txn(int'($urandom_range(15)), int'($urandom_range(70)), int'($urandom_range(40)),
              int'($urandom_range(4)), -1, -1, 2'($urandom), 1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
